// File: rtl/fp_div_ctrl.sv
// fp_div_ctrl: multi-cycle binary32 divider controller with special-operand screening and restoring mantissa divide
module fp_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, NORM, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic        [31:0] r_a;
    logic        [31:0] r_b;
    logic               r_cls_valid;
    logic               r_a_nan;
    logic               r_a_inf;
    logic               r_a_zero;
    logic               r_b_nan;
    logic               r_b_inf;
    logic               r_b_zero;
    logic        [24:0] r_rem;
    logic        [24:0] r_q;
    logic        [23:0] r_mb;
    logic signed [9:0]  r_exp;
    logic        [4:0]  r_cnt;
    logic        [31:0] r_result;
    logic               r_dbz;
    logic               r_inv;

    logic               w_sign;
    logic               w_inv_case;
    logic               w_dbz_case;
    logic               w_special;
    logic        [31:0] w_sp_result;
    logic               w_rem_ge;
    logic        [23:0] w_rem_sub;
    logic signed [9:0]  w_norm_exp;
    logic        [22:0] w_frac;
    logic        [31:0] w_norm_result;

    assign w_sign      = r_a[31] ^ r_b[31];
    assign w_inv_case  = r_a_nan | r_b_nan | (r_a_zero & r_b_zero) | (r_a_inf & r_b_inf);
    assign w_dbz_case  = !w_inv_case & r_b_zero & !r_a_inf;
    assign w_special   = w_inv_case | r_a_inf | r_b_inf | r_a_zero | r_b_zero;
    assign w_sp_result = w_inv_case ? 32'h7FC0_0000 :
                         (r_a_inf | r_b_zero) ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};

    assign w_rem_ge  = r_rem >= {1'b0, r_mb};
    assign w_rem_sub = w_rem_ge ? 24'(r_rem - {1'b0, r_mb}) : r_rem[23:0];

    assign w_norm_exp    = r_exp + (r_q[24] ? 10'sd127 : 10'sd126);
    assign w_frac        = r_q[24] ? r_q[23:1] : r_q[22:0];
    assign w_norm_result = (w_norm_exp >= 10'sd255) ? {w_sign, 8'hFF, 23'd0} :
                           (w_norm_exp <= 10'sd0)   ? {w_sign, 31'd0} :
                           {w_sign, w_norm_exp[7:0], w_frac};

    assign in_ready    = r_state == IDLE;
    assign busy        = r_state != IDLE;
    assign out_valid   = r_state == DONE;
    assign result      = r_result;
    assign div_by_zero = r_dbz;
    assign invalid     = r_inv;

    // State register; reset drops any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state sequencing; CHECK spends one cycle classifying and one deciding
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? CHECK : IDLE;
            CHECK:   w_next = !r_cls_valid ? CHECK : (w_special ? DONE : DIVIDE);
            DIVIDE:  w_next = (r_cnt == 5'd0) ? NORM : DIVIDE;
            NORM:    w_next = DONE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, classification, divide datapath and result/flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cls_valid <= 1'b0;
            r_a_nan     <= 1'b0;
            r_a_inf     <= 1'b0;
            r_a_zero    <= 1'b0;
            r_b_nan     <= 1'b0;
            r_b_inf     <= 1'b0;
            r_b_zero    <= 1'b0;
            r_rem       <= '0;
            r_q         <= '0;
            r_mb        <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_dbz       <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_cls_valid <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!r_cls_valid) begin
                        r_cls_valid <= 1'b1;
                        r_a_nan     <= (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
                        r_a_inf     <= (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
                        r_a_zero    <= r_a[30:23] == 8'h00;
                        r_b_nan     <= (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
                        r_b_inf     <= (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
                        r_b_zero    <= r_b[30:23] == 8'h00;
                    end else if (w_special) begin
                        r_result <= w_sp_result;
                        r_dbz    <= w_dbz_case;
                        r_inv    <= w_inv_case;
                    end else begin
                        r_dbz <= 1'b0;
                        r_inv <= 1'b0;
                        r_rem <= {2'b01, r_a[22:0]};
                        r_mb  <= {1'b1, r_b[22:0]};
                        r_q   <= '0;
                        r_exp <= {2'b00, r_a[30:23]} - {2'b00, r_b[30:23]};
                        r_cnt <= 5'd24;
                    end
                end
                DIVIDE: begin
                    r_q   <= {r_q[23:0], w_rem_ge};
                    r_rem <= {w_rem_sub, 1'b0};
                    r_cnt <= r_cnt - 5'd1;
                end
                NORM: r_result <= w_norm_result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_ctrl.sv
// tb_fp_div_ctrl: directed checks of fp_div_ctrl results, flags, latency, backpressure and reset
module tb_fp_div_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        div_by_zero;
    logic        invalid;
    logic        busy;
    int          vectors = 0;
    int          errs = 0;

    fp_div_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero), .invalid(invalid), .busy(busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic dbz, input logic inv);
        chk({tag, "_result"}, result, res);
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(dbz));
        chk({tag, "_invalid"}, 32'(invalid), 32'(inv));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] res, input logic dbz, input logic inv, input int lat);
        issue(tag, av, bv);
        wait_done(tag, lat);
        check_out(tag, res, dbz, inv);
        take(tag);
    endtask

    initial begin
        logic seen;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        op("six_by_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28);
        op("neg_six",     32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 1'b0, 28);
        op("one_third",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 28);
        op("one_by_one",  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 28);
        op("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 2);
        op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2);
        op("inf_inf",     32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2);
        op("two_by_inf",  32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
        op("nan_in",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2);
        op("inf_by_neg",  32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 1'b0, 2);
        op("overflow",    32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 1'b0, 28);
        op("underflow",   32'h0080_0000, 32'h4F00_0000, 32'h0000_0000, 1'b0, 1'b0, 28);

        issue("stall", 32'h3F80_0000, 32'h4040_0000);
        wait_done("stall", 28);
        check_out("stall", 32'h3EAA_AAAA, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 32'h4000_0000;
            b = 32'h0000_0000;
            @(negedge clk);
            chk("stall_ov", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            check_out("stall_hold", 32'h3EAA_AAAA, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        take("stall");
        @(negedge clk);
        chk("stall_idle_busy", 32'(busy), 32'd0);

        issue("midrst", 32'h40C0_0000, 32'h4000_0000);
        repeat (12) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        chk("midrst_invalid", 32'(invalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("midrst_no_stale_ov", 32'(seen), 32'd0);
        op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/fp_div_ctrl.md
# fp_div_ctrl

Multi-cycle IEEE-754 single-precision divide controller. It accepts one operand pair through a valid/ready handshake and screens special operands. Normal cases are sequenced through a one-bit-per-cycle restoring mantissa divide, then the result is normalized, packed, and held until the consumer takes it. It sits between the FP issue logic and the writeback path, and it is the sequential replacement for the combinational 24-bit mantissa divider in the FP unit.

## Interface
- No parameters. The format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair. High only in IDLE.
- a  input  32  dividend (binary32).
- b  input  32  divisor (binary32).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- result  output  32  quotient (binary32).
- div_by_zero  output  1  a is finite non-zero and b is zero.
- invalid  output  1  result is the canonical NaN.
- busy  output  1  state is not IDLE.

## Operation
- **States:** IDLE, CHECK, DIVIDE, NORM, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready, register a and b, then go to CHECK.
- **CHECK:** unpack the operands; denormals are flushed to zero. sign = sa^sb.
  - Either operand NaN, 0/0, or inf/inf: result=0x7FC00000, invalid=1, go to DONE.
  - Finite non-zero / 0: result={sign,0xFF,0}, div_by_zero=1, go to DONE.
  - inf / finite: result={sign,0xFF,0}, go to DONE.
  - 0 / non-zero, or finite / inf: result={sign,31'b0}, go to DONE.
  - Otherwise:
    - ma={1,fa}, mb={1,fb}.
    - Remainder register (25 bits) = ma, q=0.
    - Exponent difference e = ea - eb, held as a 10-bit signed value.
    - Counter = 24. Go to DIVIDE.
- **DIVIDE:** one step per cycle, 25 cycles.
  - If rem>=mb: q bit 1, rem=rem-mb. Otherwise q bit 0.
  - Then rem<<=1 and q is shifted MSB-first.
  - Leave for NORM when the counter reaches 0.
  - q[24] has weight 2^0 and q[0] has weight 2^-24.
- **NORM:**
  - If q[24]=1: frac=q[23:1], exp=e+127.
  - Otherwise: frac=q[22:0], exp=e+126.
  - Rounding is truncation toward zero. The remainder is discarded.
  - exp>=255 gives {sign,0xFF,0} (overflow to inf, no flag).
  - exp<=0 gives {sign,31'b0} (underflow flush).
  - Otherwise the result is {sign,exp[7:0],frac}. Go to DONE.
- **DONE:**
  - out_valid=1. result, div_by_zero and invalid are held stable.
  - On out_ready, go to IDLE.
  - The flags and result keep their values until the next CHECK writes them.
- No overlap between operations. in_valid is ignored outside IDLE.
- **Reset:** asserting rst in any state, including mid-DIVIDE, forces IDLE immediately. The operation in progress is dropped and no out_valid is produced for it.

## Timing
- **Reset values:**
  - out_valid=0, result=0, div_by_zero=0, invalid=0, busy=0.
  - in_ready=1, driven from state=IDLE.
- **Accept:** the operand pair is taken at the edge where in_valid&in_ready. Call this edge 0.
- **Special-case latency:** CHECK in the cycle after edge 0; out_valid high after edge 2.
- **Normal latency:**
  - CHECK after edge 1.
  - DIVIDE across edges 2..26.
  - NORM after edge 27.
  - out_valid high after edge 28.
- **Handshake:**
  - The result transfers at the edge where out_valid&out_ready. out_valid drops after that edge and in_ready rises.
  - The next operand pair can be accepted one cycle after the transfer edge.
  - out_ready held low stalls DONE indefinitely with no output change.
  - out_ready high before DONE has no effect.
- **Minimum issue interval:** 30 cycles for a normal operation with out_ready held high, 4 cycles for a special case.

## Test plan
- **Normal division:**
  - a=0x40C00000 (6.0), b=0x40000000 (2.0): result=0x40400000, flags 0, out_valid 28 cycles after accept.
  - a=0xC0C00000, b=0x40000000: result=0xC0400000.
- **Truncation:** a=0x3F800000, b=0x40400000 (1/3): result=0x3EAAAAAA, not 0x3EAAAAAB. Also a=b=0x3F800000: result=0x3F800000.
- **Special cases, each with out_valid 2 cycles after accept:**
  - 0x3F800000/0x00000000 gives 0x7F800000 with div_by_zero=1.
  - 0/0 gives 0x7FC00000 with invalid=1.
  - 0x7F800000/0x7F800000 gives 0x7FC00000 with invalid=1.
  - 0x40000000/0x7F800000 gives 0x00000000.
- **Exponent range:**
  - 0x7F000000/0x3E800000 gives 0x7F800000 (overflow).
  - 0x00800000/0x4F000000 gives 0x00000000 (underflow flush).
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles in DONE: result, flags and out_valid stay stable, in_ready=0, and in_valid pulses are ignored.
  - Release out_ready: transfer happens, then in_ready=1 on the next cycle.
- **Reset mid-operation:**
  - Assert rst 10 cycles into DIVIDE: all outputs return to their reset values asynchronously, in_ready=1, and no stale out_valid appears.
  - A new 6.0/2.0 issued after reset returns 0x40400000.
